// File: rtl/xrv_sched_pkg.sv
// Shared types for the pending-request scheduler.
package xrv_sched_pkg;

    typedef enum logic {
        SCHED_EMPTY = 1'b0,
        SCHED_HOLD  = 1'b1
    } sched_state_e;

endpackage

// File: rtl/xrv_ff_one.sv
// Find-first-one: index of the lowest set bit of data; empty when no bit is set.
module xrv_ff_one #(
    parameter  int DATA_WIDTH_P = 8,
    localparam int IDX_W        = $clog2(DATA_WIDTH_P)
) (
    input  logic [DATA_WIDTH_P-1:0] data,
    output logic [IDX_W-1:0]        idx,
    output logic                    empty
);

    // Scan high to low so the lowest set bit is the last assignment to stick.
    always_comb begin
        idx = '0;
        for (int i = DATA_WIDTH_P - 1; i >= 0; i--) begin
            if (data[i]) idx = IDX_W'(i);
        end
    end

    assign empty = ~|data;

endmodule

// File: rtl/xrv_pend_sched.sv
// Pending-request scheduler with a registered valid/ready grant port.
// Define XRV_PEND_SCHED_RR_EN for round-robin selection; default is fixed lowest-index priority.
module xrv_pend_sched
    import xrv_sched_pkg::*;
#(
    parameter  int NUM_REQ_P = 8,
    localparam int IDX_W     = $clog2(NUM_REQ_P)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [NUM_REQ_P-1:0] set_i,
    input  logic [NUM_REQ_P-1:0] clr_i,
    input  logic                 flush_i,
    output logic                 gnt_valid_o,
    input  logic                 gnt_ready_i,
    output logic [IDX_W-1:0]     gnt_idx_o,
    output logic [NUM_REQ_P-1:0] gnt_onehot_o,
    output logic [NUM_REQ_P-1:0] pend_o,
    output logic                 busy_o
);

    sched_state_e         state_q;
    logic [NUM_REQ_P-1:0] pend_q;
    logic [NUM_REQ_P-1:0] cand;
    logic [NUM_REQ_P-1:0] pick_oh;
    logic [IDX_W-1:0]     pick;
    logic [IDX_W-1:0]     cand_idx;
    logic                 cand_empty;
    logic                 any;
    logic                 load;

    assign cand = pend_q & ~clr_i;

    xrv_ff_one #(.DATA_WIDTH_P(NUM_REQ_P)) u_ff_cand (
        .data  (cand),
        .idx   (cand_idx),
        .empty (cand_empty)
    );

`ifdef XRV_PEND_SCHED_RR_EN
    logic [IDX_W-1:0]     ptr_q;
    logic [NUM_REQ_P-1:0] hi_mask;
    logic [NUM_REQ_P-1:0] hi;
    logic [IDX_W-1:0]     hi_idx;
    logic                 hi_empty;

    // Strictly above the last loaded index; wrap to cand when nothing is above.
    always_comb begin
        hi_mask = '0;
        for (int j = 0; j < NUM_REQ_P; j++) begin
            hi_mask[j] = (IDX_W'(j) > ptr_q);
        end
    end

    assign hi = cand & hi_mask;

    xrv_ff_one #(.DATA_WIDTH_P(NUM_REQ_P)) u_ff_hi (
        .data  (hi),
        .idx   (hi_idx),
        .empty (hi_empty)
    );

    assign pick = hi_empty ? cand_idx : hi_idx;

    // Pointer survives flush; only a real load advances it.
    always_ff @(posedge clk_i) begin
        if (rst_i)     ptr_q <= '0;
        else if (load) ptr_q <= pick;
    end
`else
    assign pick = cand_idx;
`endif

    assign any     = ~cand_empty;
    assign load    = any & ~flush_i & ((state_q == SCHED_EMPTY) | gnt_ready_i);
    assign pick_oh = {{(NUM_REQ_P-1){1'b0}}, 1'b1} << pick;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= SCHED_EMPTY;
            gnt_idx_o <= '0;
            pend_q    <= '0;
        end else if (flush_i) begin
            state_q <= SCHED_EMPTY;
            pend_q  <= '0;
        end else begin
            // set_i is OR-ed last so it wins over clr_i and over the bit being loaded.
            pend_q <= (pend_q & ~clr_i & ~(load ? pick_oh : '0)) | set_i;
            if (load) begin
                state_q   <= SCHED_HOLD;
                gnt_idx_o <= pick;
            end else if (gnt_ready_i) begin
                state_q <= SCHED_EMPTY;
            end
        end
    end

    assign gnt_valid_o  = (state_q == SCHED_HOLD);
    assign gnt_onehot_o = gnt_valid_o ? ({{(NUM_REQ_P-1){1'b0}}, 1'b1} << gnt_idx_o) : '0;
    assign pend_o       = pend_q;
    assign busy_o       = (|pend_q) | gnt_valid_o;

endmodule

// File: tb/tb_xrv_pend_sched.sv
// Directed bench for xrv_pend_sched (NUM_REQ_P=8); expectations follow XRV_PEND_SCHED_RR_EN.
module tb_xrv_pend_sched;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] set_v;
    logic [N-1:0] clr_v;
    logic         flush;
    logic         ready;
    logic         gnt_valid;
    logic [2:0]   gnt_idx;
    logic [N-1:0] gnt_onehot;
    logic [N-1:0] pend;
    logic         busy;

    int n_chk  = 0;
    int n_fail = 0;

    xrv_pend_sched #(.NUM_REQ_P(N)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .set_i        (set_v),
        .clr_i        (clr_v),
        .flush_i      (flush),
        .gnt_valid_o  (gnt_valid),
        .gnt_ready_i  (ready),
        .gnt_idx_o    (gnt_idx),
        .gnt_onehot_o (gnt_onehot),
        .pend_o       (pend),
        .busy_o       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] set_v;
        logic [N-1:0] clr_v;
        logic         flush;
        logic         ready;
        logic         exp_valid;
        logic [2:0]   exp_idx;
        logic [N-1:0] exp_pend;
        logic         exp_busy;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Apply inputs for one cycle, then sample #1 after the rising edge.
    task automatic step(input logic [N-1:0] s, input logic [N-1:0] c, input logic f, input logic r);
        set_v = s;
        clr_v = c;
        flush = f;
        ready = r;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step('0, '0, 1'b0, 1'b0);
        rst = 1'b0;
    endtask

    logic [2:0] prev_idx;
    logic [N-1:0] oh;

    initial begin
        rst   = 1'b1;
        set_v = '0;
        clr_v = '0;
        flush = 1'b0;
        ready = 1'b0;

        // Reset held 3 cycles with all sets asserted
        for (int i = 0; i < 3; i++) step(8'hFF, '0, 1'b0, 1'b0);
        chk("rst_valid", gnt_valid, 0);
        chk("rst_idx", gnt_idx, 0);
        chk("rst_onehot", gnt_onehot, 0);
        chk("rst_pend", pend, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;
        step(8'hFF, '0, 1'b0, 1'b0);
        chk("rst_rel_pend", pend, 8'hFF);
        chk("rst_rel_valid", gnt_valid, 0);
        do_reset();

        // Rows 0-4: burst of three then drain; rows 5-9: cancel of a pending bit
        vecs[0] = '{8'hA4, 8'h00, 0, 1, 0, 3'd0, 8'hA4, 1};
        vecs[1] = '{8'h00, 8'h00, 0, 1, 1, 3'd2, 8'hA0, 1};
        vecs[2] = '{8'h00, 8'h00, 0, 1, 1, 3'd5, 8'h80, 1};
        vecs[3] = '{8'h00, 8'h00, 0, 1, 1, 3'd7, 8'h00, 1};
        vecs[4] = '{8'h00, 8'h00, 0, 1, 0, 3'd0, 8'h00, 0};
        vecs[5] = '{8'h24, 8'h00, 0, 0, 0, 3'd0, 8'h24, 1};
        vecs[6] = '{8'h00, 8'h00, 0, 0, 1, 3'd2, 8'h20, 1};
        vecs[7] = '{8'h00, 8'h20, 0, 0, 1, 3'd2, 8'h00, 1};
        vecs[8] = '{8'h00, 8'h00, 0, 1, 0, 3'd0, 8'h00, 0};
        vecs[9] = '{8'h00, 8'h00, 0, 1, 0, 3'd0, 8'h00, 0};
        for (int v = 0; v < 10; v++) begin
            step(vecs[v].set_v, vecs[v].clr_v, vecs[v].flush, vecs[v].ready);
            chk($sformatf("vec%0d_valid", v), gnt_valid, vecs[v].exp_valid);
            chk($sformatf("vec%0d_pend", v), pend, vecs[v].exp_pend);
            chk($sformatf("vec%0d_busy", v), busy, vecs[v].exp_busy);
            oh = vecs[v].exp_valid ? (8'h01 << vecs[v].exp_idx) : 8'h00;
            chk($sformatf("vec%0d_onehot", v), gnt_onehot, oh);
            if (vecs[v].exp_valid) chk($sformatf("vec%0d_idx", v), gnt_idx, vecs[v].exp_idx);
        end

        // Held grant stays put while ready is low, even with new sets arriving
        do_reset();
        step(8'hA4, '0, 1'b0, 1'b0);
        step('0, '0, 1'b0, 1'b0);
        chk("hold_first_idx", gnt_idx, 2);
        step(8'h01, 8'h04, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            chk("hold_valid", gnt_valid, 1);
            chk("hold_idx", gnt_idx, 2);
            step('0, '0, 1'b0, 1'b0);
        end
        chk("hold_pend", pend, 8'hA1);
        step('0, '0, 1'b0, 1'b1);
        chk("hold_next_valid", gnt_valid, 1);
`ifdef XRV_PEND_SCHED_RR_EN
        chk("hold_next_idx", gnt_idx, 5);
        chk("hold_next_pend", pend, 8'h81);
`else
        chk("hold_next_idx", gnt_idx, 0);
        chk("hold_next_pend", pend, 8'hA0);
`endif

        // Flush during HOLD with a pending backlog; flush-cycle sets are dropped
        do_reset();
        step(8'h01, '0, 1'b0, 1'b0);
        step(8'h0F, '0, 1'b0, 1'b0);
        chk("pre_flush_valid", gnt_valid, 1);
        chk("pre_flush_idx", gnt_idx, 0);
        chk("pre_flush_pend", pend, 8'h0F);
        step(8'hF0, '0, 1'b1, 1'b0);
        chk("flush_valid", gnt_valid, 0);
        chk("flush_pend", pend, 0);
        chk("flush_busy", busy, 0);
        chk("flush_onehot", gnt_onehot, 0);

        // Continuous re-assertion of two sources under continuous ready
        step(8'h03, '0, 1'b0, 1'b1);
        chk("cont_pend", pend, 8'h03);
        chk("cont_first_valid", gnt_valid, 0);
        prev_idx = 3'd7;
        for (int k = 0; k < 8; k++) begin
            step(8'h03, '0, 1'b0, 1'b1);
            chk("cont_valid", gnt_valid, 1);
`ifdef XRV_PEND_SCHED_RR_EN
            chk("cont_idx_range", {31'd0, gnt_idx > 3'd1}, 0);
            if (k > 0) chk("cont_idx_alt", gnt_idx, {2'b00, ~prev_idx[0]});
`else
            chk("cont_idx", gnt_idx, 0);
`endif
            prev_idx = gnt_idx;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
